// File: rtl/game_pkg.sv
// Shared screen constants, reset cursor position, direction indices and the
// auto-repeat FSM encoding for game_input_ctrl.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_MAX    = SCREEN_W - 1;
  localparam int Y_MAX    = SCREEN_H - 1;
  localparam int X_RESET  = 320;
  localparam int Y_RESET  = 240;

  // Bit positions of the four direction buttons inside the direction vectors.
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    DIR_IDLE   = 2'd0,
    DIR_DELAY  = 2'd1,
    DIR_REPEAT = 2'd2
  } dir_state_e;

  function automatic logic [31:0] tile_index(input logic [9:0] x,
                                             input logic [8:0] y,
                                             input int cell_log2);
    tile_index = 32'(y >> cell_log2) * 32'(SCREEN_W >> cell_log2)
               + 32'(x >> cell_log2);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a counter debouncer; the debounced level
// flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic db_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreeing sample clears the count, so only an unbroken run flips db.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Debounced button front end driving a saturating tile cursor and a sticky
// press flag. Define GAME_INPUT_AUTOREPEAT_EN to add held-direction repeat.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP            = 32,
  parameter int CELL_LOG2       = 5,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_press,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        pr_reset,
  output logic        pressed,
  output logic [9:0]  x_game,
  output logic [8:0]  y_game,
  output logic [31:0] VGAid
);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] YMAX_W  = 11'(Y_MAX);
  localparam logic [31:0] VGA_RST = tile_index(10'(X_RESET), 9'(Y_RESET), CELL_LOG2);

  // Bit 0 is the press button; bits 4:1 are the directions (DIR_* + 1).
  logic [4:0] btn_raw, db, db_prev_q, rise;
  logic [3:0] dir_rise, dir_db, dir_step, mv;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up, btn_press};

  for (genvar g = 0; g < 5; g++) begin : g_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_i (clock),
      .rst_i (reset),
      .btn_i (btn_raw[g]),
      .db_o  (db[g])
    );
  end

  assign rise     = db & ~db_prev_q;
  assign dir_rise = rise[4:1];
  assign dir_db   = db[4:1];

`ifdef GAME_INPUT_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [3:0] rep_step;

  for (genvar g = 0; g < 4; g++) begin : g_rep
    dir_state_e    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;

    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_step[g] = 1'b0;
      case (state_q)
        DIR_IDLE: begin
          cnt_d = '0;
          if (dir_rise[g]) state_d = DIR_DELAY;
        end
        DIR_DELAY: begin
          if (!dir_db[g]) begin
            state_d = DIR_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_LAST) begin
            state_d     = DIR_REPEAT;
            cnt_d       = '0;
            rep_step[g] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DIR_REPEAT: begin
          if (!dir_db[g]) begin
            state_d = DIR_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            cnt_d       = '0;
            rep_step[g] = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = DIR_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= DIR_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign dir_step = dir_rise | rep_step;
`else
  assign dir_step = dir_rise;
`endif

  logic        pressed_q, pressed_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [31:0] vga_q, vga_d;
  logic [10:0] x_inc, y_inc;

  // Movement is frozen while an unacknowledged press is pending.
  assign mv    = dir_step & {4{~pressed_q}};
  assign x_inc = {1'b0, x_q} + STEP_W;
  assign y_inc = {2'b00, y_q} + STEP_W;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    pressed_d = pressed_q;
    vga_d     = tile_index(x_q, y_q, CELL_LOG2);

    if (mv[DIR_RIGHT] && !mv[DIR_LEFT]) begin
      x_d = (x_inc > XMAX_W) ? XMAX_W[9:0] : x_inc[9:0];
    end else if (mv[DIR_LEFT] && !mv[DIR_RIGHT]) begin
      x_d = ({1'b0, x_q} < STEP_W) ? 10'd0 : x_q - STEP_W[9:0];
    end

    if (mv[DIR_DOWN] && !mv[DIR_UP]) begin
      y_d = (y_inc > YMAX_W) ? YMAX_W[8:0] : y_inc[8:0];
    end else if (mv[DIR_UP] && !mv[DIR_DOWN]) begin
      y_d = ({2'b00, y_q} < STEP_W) ? 9'd0 : y_q - STEP_W[8:0];
    end

    if (rise[0]) begin
      pressed_d = 1'b1;
    end else if (pr_reset) begin
      pressed_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_prev_q <= '0;
      pressed_q <= 1'b0;
      x_q       <= 10'(X_RESET);
      y_q       <= 9'(Y_RESET);
      vga_q     <= VGA_RST;
    end else begin
      db_prev_q <= db;
      pressed_q <= pressed_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vga_q     <= vga_d;
    end
  end

  assign pressed = pressed_q;
  assign x_game  = x_q;
  assign y_game  = y_q;
  assign VGAid   = vga_q;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with a cursor-move scoreboard; optional
// auto-repeat checks follow GAME_INPUT_AUTOREPEAT_EN.
module tb_game_input_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_press, btn_up, btn_down, btn_left, btn_right, pr_reset;
  logic        pressed;
  logic [9:0]  x_game;
  logic [8:0]  y_game;
  logic [31:0] vga_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 0;

  logic [18:0] exp_q[$];
  int          move_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  game_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .STEP(32),
    .CELL_LOG2(5),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .btn_press (btn_press),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .pr_reset  (pr_reset),
    .pressed   (pressed),
    .x_game    (x_game),
    .y_game    (y_game),
    .VGAid     (vga_id)
  );

  function automatic logic [31:0] tile(input logic [9:0] x, input logic [8:0] y);
    tile = (32'(y) / 32) * 20 + 32'(x) / 32;
  endfunction

  // Scoreboard: every cursor change must match the next queued expectation,
  // and VGAid must track the previous cycle's coordinates.
  logic [9:0]  prev_x;
  logic [8:0]  prev_y;
  logic        prev_ok = 1'b0;
  logic [18:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        n_checks++;
        if (vga_id !== tile(prev_x, prev_y)) begin
          n_fail++;
          $error("FAIL vgaid_track observed=%0d expected=%0d", vga_id, tile(prev_x, prev_y));
        end
        if (x_game !== prev_x || y_game !== prev_y) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL move_expected observed=0 expected=1");
          end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (x_game !== e[18:9]) begin
              n_fail++;
              $error("FAIL move_x observed=%0d expected=%0d", x_game, e[18:9]);
            end
            n_checks++;
            if (y_game !== e[8:0]) begin
              n_fail++;
              $error("FAIL move_y observed=%0d expected=%0d", y_game, e[8:0]);
            end
            move_cyc.push_back(cyc);
          end
        end
      end
      prev_x  = x_game;
      prev_y  = y_game;
      prev_ok = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_press = v;
      1: btn_up    = v;
      2: btn_down  = v;
      3: btn_left  = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic tap(input int idx, input int hold);
    set_btn(idx, 1'b1);
    tick(hold);
    set_btn(idx, 1'b0);
    tick(12);
  endtask

  task automatic push_xy(input int xe, input int ye);
    exp_q.push_back({10'(xe), 9'(ye)});
  endtask

  task automatic ack();
    pr_reset = 1'b1;
    tick(1);
    pr_reset = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_x", x_game, 320);
    chk("rst_y", y_game, 240);
    chk("rst_vgaid", vga_id, 150);
    chk("rst_pressed", pressed, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {btn_press, btn_up, btn_down, btn_left, btn_right, pr_reset} = '0;
    tick(3);
    check_reset_values();
    rst = 1'b0;
    tick(2);

    // Clean right press: exactly one step, tile follows a cycle later.
    push_xy(352, 240);
    tap(4, 10);
    chk("right_queue_drained", exp_q.size(), 0);
    chk("right_x", x_game, 352);
    chk("right_vgaid", vga_id, 151);

    // Short glitch on press is rejected.
    tap(0, 3);
    chk("glitch_pressed", pressed, 0);

    // Held press sets the flag; measure drive-to-flag latency.
    set_btn(0, 1'b1);
    lat = 0;
    while (pressed !== 1'b1 && lat < 30) begin
      tick(1);
      lat++;
    end
    chk("press_set", pressed, 1);
    if (lat < 8) tick(8 - lat);
    set_btn(0, 1'b0);
    tick(12);
    chk("press_sticky", pressed, 1);
    ack();
    chk("press_ack", pressed, 0);

    // Movement frozen while pressed.
    tap(0, 8);
    chk("press_again", pressed, 1);
    tap(3, 10);
    chk("frozen_x", x_game, 352);
    ack();
    chk("ack2", pressed, 0);
    tick(2);

    // Press edge landing in the same cycle as the acknowledge: set wins.
    set_btn(0, 1'b1);
    tick(lat - 1);
    pr_reset = 1'b1;
    tick(1);
    pr_reset = 1'b0;
    chk("set_wins", pressed, 1);
    tick(1);
    chk("set_wins_hold", pressed, 1);
    set_btn(0, 1'b0);
    tick(12);
    ack();
    tick(2);
    chk("ack3", pressed, 0);

    // Walk right to 608, then saturate at 639.
    for (int i = 1; i <= 8; i++) begin
      push_xy(352 + 32 * i, 240);
      tap(4, 10);
    end
    chk("x_608", x_game, 608);
    push_xy(639, 240);
    tap(4, 10);
    chk("x_sat1", x_game, 639);
    tap(4, 10);
    chk("x_sat2", x_game, 639);

    // Walk up to 0 and stay there.
    for (int i = 1; i <= 7; i++) begin
      push_xy(639, 240 - 32 * i);
      tap(1, 10);
    end
    push_xy(639, 0);
    tap(1, 10);
    chk("y_zero", y_game, 0);
    tap(1, 10);
    chk("y_sat", y_game, 0);

    // Opposing pairs cancel; orthogonal pair applies both.
    btn_left = 1'b1; btn_right = 1'b1;
    tick(10);
    btn_left = 1'b0; btn_right = 1'b0;
    tick(12);
    chk("lr_cancel_x", x_game, 639);
    btn_up = 1'b1; btn_down = 1'b1;
    tick(10);
    btn_up = 1'b0; btn_down = 1'b0;
    tick(12);
    chk("ud_cancel_y", y_game, 0);
    push_xy(607, 32);
    btn_left = 1'b1; btn_down = 1'b1;
    tick(10);
    btn_left = 1'b0; btn_down = 1'b0;
    tick(12);
    chk("diag_x", x_game, 607);
    chk("diag_y", y_game, 32);
    chk("edge_queue_drained", exp_q.size(), 0);

    // Reset back to centre, then hold down.
    rst = 1'b1;
    #1;
    check_reset_values();
    tick(3);
    rst = 1'b0;
    tick(2);
    move_cyc.delete();
`ifdef GAME_INPUT_AUTOREPEAT_EN
    for (int i = 1; i <= 5; i++) push_xy(320, 240 + 32 * i);
`else
    push_xy(320, 272);
`endif
    set_btn(2, 1'b1);
    tick(49);
    set_btn(2, 1'b0);
    tick(15);
    chk("hold_queue_drained", exp_q.size(), 0);
`ifdef GAME_INPUT_AUTOREPEAT_EN
    chk("repeat_count", move_cyc.size(), 5);
    if (move_cyc.size() >= 4) begin
      chk("repeat_delay_gap", move_cyc[1] - move_cyc[0], RD);
      chk("repeat_period_gap1", move_cyc[2] - move_cyc[1], RP);
      chk("repeat_period_gap2", move_cyc[3] - move_cyc[2], RP);
    end
    chk("hold_y", y_game, 400);
`else
    chk("single_step_count", move_cyc.size(), 1);
    chk("hold_y", y_game, 272);
`endif

    // Reset while pressed and with up held mid-repeat; one step afterwards.
    tap(0, 10);
    chk("pre_rst_pressed", pressed, 1);
    set_btn(1, 1'b1);
    tick(40);
    rst = 1'b1;
    #1;
    check_reset_values();
    push_xy(320, 208);
    tick(3);
    rst = 1'b0;
    tick(15);
    set_btn(1, 1'b0);
    tick(15);
    chk("post_rst_y", y_game, 208);
    chk("post_rst_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
